sym_slicer: RTL and testbench
=============================

SYM_SLICER -- requirements
Module: sym_slicer

Interface
REQ-001 SHALL have parameter LOG2_AVG, default 10, meaning averaging window of 2^LOG2_AVG symbols.
REQ-002 SHALL have parameter REF_INIT, default 18'sd65536, meaning initial decision threshold (1s17, equals 2a).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sam_clk_en  input  1  sample-rate enable; sym_clk_en is only ever high on cycles where this is high.
REQ-006 SHALL have port sym_clk_en  input  1  symbol-rate strobe marking the sampling instant.
REQ-007 SHALL have port in  input  18  signed 1s17 output of the SRRC RX matched filter.
REQ-008 SHALL have port sym_out  output  2  Gray-coded 4-ASK decision.
REQ-009 SHALL have port sym_valid  output  1  one-cycle pulse qualifying sym_out and err_out.
REQ-010 SHALL have port err_out  output  18  signed error: sample minus reconstructed level.
REQ-011 SHALL have port ref_level  output  18  current threshold estimate (mean |x|).
REQ-012 SHALL have port err_pow  output  18  mean squared error over the last window, 0s18.
REQ-013 SHALL have port win_done  output  1  one-cycle pulse when ref_level and err_pow update.

Function
REQ-014 SHALL capture in on every cycle where sym_clk_en=1, and ignore in on all other cycles.
REQ-015 SHALL compute |x|, saturating -131072 to 131071.
REQ-016 SHALL decide: x>=ref -> 2'b10 (+3a); 0<=x<ref -> 2'b11 (+a); -ref<x<0 -> 2'b01 (-a); x<=-ref -> 2'b00 (-3a); x=0 -> +a; |x|=ref -> outer level.
REQ-017 SHALL reconstruct a=ref>>>1 and 3a=ref+(ref>>>1), and SHALL compute err_out=x-level with saturation to 18 bits.
REQ-018 SHALL drive sym_out, err_out and sym_valid exactly 2 clk cycles after the capturing sym_clk_en cycle.
REQ-019 SHALL hold sym_out and err_out between pulses.
REQ-020 SHALL accumulate |x| in an unsigned (18+LOG2_AVG)-bit accumulator, and SHALL accumulate (err^2)>>17 in a (18+LOG2_AVG)-bit accumulator saturating at all-ones.
REQ-021 SHALL count symbols with a LOG2_AVG-bit counter that wraps from 2^LOG2_AVG-1 to 0.
REQ-022 On the symbol that wraps the counter, SHALL load ref_level=acc_abs>>LOG2_AVG and err_pow=acc_err>>LOG2_AVG (saturated to 18 bits), clear both accumulators, and pulse win_done.
REQ-023 The wrapping symbol SHALL be included in its own window, and SHALL be decided against the old ref.
REQ-024 win_done SHALL assert on the same cycle as that symbol's sym_valid.
REQ-025 SHALL clamp ref_level to a minimum of 1.
REQ-026 SHALL implement FSM ACQ->TRACK; ACQ is entered at reset; the first win_done moves the FSM to TRACK; TRACK is held until reset.
REQ-027 While in ACQ, err_pow SHALL read 0.
REQ-028 When a new sym_clk_en arrives while the pipeline is busy, SHALL accept it without a stall (pipeline fully pipelined, throughput 1 symbol/cycle).

Reset
REQ-029 When reset=0 at a clk edge, SHALL return all state to reset values: sym_out=2'b00, err_out=0, sym_valid=0, win_done=0, ref_level=REF_INIT, err_pow=0, accumulators=0, counter=0, FSM=ACQ, pipeline flushed.
REQ-030 Reset mid-window SHALL discard the partial window, and no win_done SHALL follow for it.

Structure
REQ-031 SHALL place in the shared MOD465 package: Gray symbol codes (SYM_M3, SYM_M1, SYM_P1, SYM_P3), the FSM state encodings, and the 1s17 saturation limits.
REQ-032 SHALL use one sub-module, sym_avg_acc (accumulator + counter + divide-by-shift).
REQ-033 SHALL instantiate sym_avg_acc twice: once for |x|, once for err^2.

Verification (LOG2_AVG=2, REF_INIT=65536 unless stated)
REQ-034 in=98304 with sym_clk_en -> sym_out=10 and err_out=0, two cycles later.
REQ-035 in=0 -> sym_out=11 and err_out=-32768; in=-65536 -> sym_out=00 and err_out=32768.
REQ-036 in=-131072 -> sym_out=00; |x| accumulated as 131071.
REQ-037 Four symbols of |x|=40000 -> win_done on the 4th sym_valid; ref_level=40000; FSM=TRACK; next in=39999 -> 11; in=40000 -> 10.
REQ-038 Reset asserted after two symbols of a window, then four symbols of 20000 -> ref_level=20000, with no earlier win_done.
REQ-039 sym_clk_en on consecutive cycles -> sym_valid on consecutive cycles; no decision is dropped.

Source files
------------

// File: rtl/sym_slicer_pkg.sv
// Shared constants for the 4-ASK symbol slicer: Gray symbol codes, FSM states,
// and the signed 1s17 saturation limits with the helpers that apply them.
// Pure definitions: no clocks, no state, no handshake.
package sym_slicer_pkg;

  // Gray-coded 4-ASK decisions (adjacent amplitude levels differ in one bit)
  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  // ACQ until the first averaging window completes, TRACK afterwards
  typedef enum logic {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } slicer_state_e;

  // 1s17 limits
  localparam logic signed [17:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [17:0] SAT_MIN = 18'sh20000;

  // Clamp a 20-bit intermediate back into 1s17
  function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
    if (v > 20'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (v < 20'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return 18'(v);
    end
  endfunction

  // Magnitude of a 1s17 value; the most negative code has no positive twin
  function automatic logic [17:0] abs_sat(input logic signed [17:0] v);
    if (v == SAT_MIN) begin
      return 18'(SAT_MAX);
    end else if (v[17]) begin
      return 18'(-v);
    end else begin
      return 18'(v);
    end
  endfunction

endpackage

// File: rtl/sym_slicer_if.sv
// Sample-stream / decision bundle between the matched filter and the slicer.
// master: drives enables and samples, observes decisions and statistics.
// slave : the slicer itself.
interface sym_slicer_if;
  logic               sam_clk_en;  // sample-rate enable
  logic               sym_clk_en;  // symbol sampling instant (subset of sam_clk_en)
  logic signed [17:0] in;          // 1s17 matched-filter output
  logic [1:0]         sym_out;     // Gray-coded decision
  logic               sym_valid;   // qualifies sym_out / err_out
  logic signed [17:0] err_out;     // sample minus reconstructed level
  logic signed [17:0] ref_level;   // current threshold (mean |x|)
  logic [17:0]        err_pow;     // windowed mean squared error, 0s18
  logic               win_done;    // ref_level / err_pow just updated

  modport master (
    output sam_clk_en, sym_clk_en, in,
    input  sym_out, sym_valid, err_out, ref_level, err_pow, win_done
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, in,
    output sym_out, sym_valid, err_out, ref_level, err_pow, win_done
  );
endinterface

// File: rtl/sym_avg_acc.sv
// Windowed average: sums 2^LOG2_AVG samples, then presents sum >> LOG2_AVG.
// Latency: wrap/avg_dat are combinational on the add that closes the window.
// No backpressure: one add per cycle is always accepted.
//
// Ports: clk, reset (sync, active-low); add_vld/add_dat = unsigned sample to
// accumulate; wrap = this add closes the window; avg_dat = window mean
// including the closing sample (valid when wrap is high).
module sym_avg_acc #(
  parameter int LOG2_AVG = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_vld,
  input  logic [17:0] add_dat,
  output logic        wrap,
  output logic [17:0] avg_dat
);

  localparam int AW = 18 + LOG2_AVG;

  logic [AW-1:0]       acc_q, acc_d;
  logic [LOG2_AVG-1:0] cnt_q, cnt_d;
  logic [AW:0]         sum;      // extra bit catches the carry for saturation
  logic [AW-1:0]       sum_sat;

  always_comb begin
    sum     = {1'b0, acc_q} + {{(LOG2_AVG + 1){1'b0}}, add_dat};
    sum_sat = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
    wrap    = add_vld && (cnt_q == {LOG2_AVG{1'b1}});
    // Closing sample is part of its own window, so divide the updated sum
    avg_dat = sum_sat[AW-1:LOG2_AVG];

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (add_vld) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = wrap ? '0 : sum_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sym_slicer.sv
// 4-ASK slicer with adaptive threshold (mean |x|) and windowed MSE estimate.
// Latency: decision/error appear 2 cycles after the sym_clk_en capture cycle.
// No backpressure: fully pipelined, a new symbol may arrive every cycle.
//
// Ports: clk, reset (sync, active-low); bus (slave) carries sam/sym enables,
// the 1s17 sample, the Gray decision with its error and valid pulse, and the
// window statistics ref_level / err_pow with their win_done pulse.
module sym_slicer #(
  parameter int                 LOG2_AVG = 10,
  parameter logic signed [17:0] REF_INIT = 18'sd65536
) (
  input  logic         clk,
  input  logic         reset,
  sym_slicer_if.slave  bus
);

  import sym_slicer_pkg::*;

  // Stage 1: captured sample
  logic               cap;
  logic signed [17:0] x1_q, x1_d;
  logic               v1_q, v1_d;

  // Stage 2: registered decision and statistics
  logic [1:0]         sym_q, sym_d;
  logic signed [17:0] err_q, err_d;
  logic               vld_q, vld_d;
  logic               win_q, win_d;
  logic signed [17:0] ref_q, ref_d;
  logic [17:0]        pow_q, pow_d;
  slicer_state_e      state_q;

  // Stage-2 combinational datapath
  logic signed [19:0] a_w, a3_w, lvl_w, diff_w;
  logic [1:0]         dec;
  logic signed [17:0] err_c;
  logic signed [34:0] err_w;
  logic [34:0]        sq_w;
  logic [17:0]        sq_sh;
  logic [17:0]        abs_c;

  logic               wrap_abs, wrap_err;
  logic [17:0]        avg_abs, avg_err;

  always_comb begin
    // sym_clk_en is only legal inside sam_clk_en; gating here keeps a stray
    // strobe between sample slots from being taken as a symbol.
    cap  = bus.sym_clk_en & bus.sam_clk_en;
    x1_d = cap ? bus.in : x1_q;
    v1_d = cap;

    // Reconstruction levels: a = ref/2, 3a = ref + ref/2
    a_w  = 20'(ref_q >>> 1);
    a3_w = 20'(ref_q) + a_w;

    // Ties go outward: x == ref -> +3a, x == -ref -> -3a, x == 0 -> +a
    if (x1_q >= ref_q) begin
      dec   = SYM_P3;
      lvl_w = a3_w;
    end else if (!x1_q[17]) begin
      dec   = SYM_P1;
      lvl_w = a_w;
    end else if (x1_q > -ref_q) begin
      dec   = SYM_M1;
      lvl_w = -a_w;
    end else begin
      dec   = SYM_M3;
      lvl_w = -a3_w;
    end

    diff_w = 20'(x1_q) - lvl_w;
    err_c  = sat18(diff_w);

    // err^2 peaks at 2^34 (err = -2^17); 35 bits hold the pattern exactly,
    // and >>17 rescales to 0s18 so the peak lands on 2^17.
    err_w = 35'(err_c);
    sq_w  = 35'(err_w * err_w);
    sq_sh = 18'(sq_w >> 17);

    abs_c = abs_sat(x1_q);

    // Output registers hold between decisions
    sym_d = v1_q ? dec   : sym_q;
    err_d = v1_q ? err_c : err_q;
    vld_d = v1_q;
    win_d = wrap_abs;

    // Threshold must stay positive or the decision regions collapse
    ref_d = ref_q;
    if (wrap_abs) begin
      ref_d = (avg_abs == '0) ? 18'sd1 : $signed(avg_abs);
    end
    pow_d = wrap_err ? avg_err : pow_q;
  end

  // Both averagers see the same add stream, so their windows stay aligned
  sym_avg_acc #(.LOG2_AVG(LOG2_AVG)) u_acc_abs (
    .clk     (clk),
    .reset   (reset),
    .add_vld (v1_q),
    .add_dat (abs_c),
    .wrap    (wrap_abs),
    .avg_dat (avg_abs)
  );

  sym_avg_acc #(.LOG2_AVG(LOG2_AVG)) u_acc_err (
    .clk     (clk),
    .reset   (reset),
    .add_vld (v1_q),
    .add_dat (sq_sh),
    .wrap    (wrap_err),
    .avg_dat (avg_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      x1_q  <= '0;
      v1_q  <= 1'b0;
      sym_q <= SYM_M3;
      err_q <= '0;
      vld_q <= 1'b0;
      win_q <= 1'b0;
      ref_q <= REF_INIT;
      pow_q <= '0;
    end else begin
      x1_q  <= x1_d;
      v1_q  <= v1_d;
      sym_q <= sym_d;
      err_q <= err_d;
      vld_q <= vld_d;
      win_q <= win_d;
      ref_q <= ref_d;
      pow_q <= pow_d;
    end
  end

  // Acquisition ends with the first completed window and never re-enters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ACQ;
    end else begin
      case (state_q)
        ST_ACQ:   if (wrap_abs) state_q <= ST_TRACK;
        ST_TRACK: state_q <= ST_TRACK;
        default:  state_q <= ST_ACQ;
      endcase
    end
  end

  assign bus.sym_out   = sym_q;
  assign bus.err_out   = err_q;
  assign bus.sym_valid = vld_q;
  assign bus.win_done  = win_q;
  assign bus.ref_level = ref_q;
  // The MSE figure is meaningless until a full window has been seen
  assign bus.err_pow   = (state_q == ST_TRACK) ? pow_q : '0;

endmodule

// File: tb/tb_sym_slicer.sv
module tb_sym_slicer;
  import sym_slicer_pkg::*;

  localparam int L    = 2;
  localparam int NWIN = 4;
  localparam int REF0 = 65536;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sym_slicer_if bus();

  sym_slicer #(.LOG2_AVG(L), .REF_INIT(18'sd65536)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         vld;
    logic [1:0] sym;
    int         err;
    bit         win;
    int         ref_l;
    int         pow;
  } exp_t;

  typedef struct {
    int         x;
    logic [1:0] sym;
    int         err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: symbols are processed strictly in order, each
  // decided against the threshold left by all earlier symbols.
  int         m_ref, m_pow, held_err;
  logic [1:0] held_sym;
  bit         m_track, m_win;
  int         win_abs[$];
  longint     win_sq[$];
  exp_t       prev;

  task automatic chk(input string name, input longint act, input longint want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic void model_reset();
    m_ref    = REF0;
    m_pow    = 0;
    m_track  = 1'b0;
    m_win    = 1'b0;
    held_sym = 2'b00;
    held_err = 0;
    win_abs.delete();
    win_sq.delete();
  endfunction

  function automatic void model_sym(input int x);
    int a, lvl, e, ax;
    longint sabs, ssq;
    logic [1:0] s;
    a = m_ref / 2;
    if (x >= m_ref)      begin s = 2'b10; lvl = m_ref + a;    end
    else if (x >= 0)     begin s = 2'b11; lvl = a;            end
    else if (x > -m_ref) begin s = 2'b01; lvl = -a;           end
    else                 begin s = 2'b00; lvl = -(m_ref + a); end
    e = x - lvl;
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
    ax = (x < 0) ? -x : x;
    if (ax > 131071) ax = 131071;
    win_abs.push_back(ax);
    win_sq.push_back((longint'(e) * longint'(e)) / 131072);
    held_sym = s;
    held_err = e;
    if (win_abs.size() == NWIN) begin
      sabs = 0;
      ssq  = 0;
      foreach (win_abs[i]) sabs += win_abs[i];
      foreach (win_sq[i])  ssq  += win_sq[i];
      if (ssq > (longint'(1) << (18 + L)) - 1) ssq = (longint'(1) << (18 + L)) - 1;
      m_ref   = int'(sabs / NWIN);
      if (m_ref < 1) m_ref = 1;
      m_pow   = int'(ssq / NWIN);
      m_track = 1'b1;
      m_win   = 1'b1;
      win_abs.delete();
      win_sq.delete();
    end
  endfunction

  function automatic exp_t snap(input bit v);
    exp_t r;
    r.vld   = v;
    r.sym   = held_sym;
    r.err   = held_err;
    r.win   = m_win;
    r.ref_l = m_ref;
    r.pow   = m_track ? m_pow : 0;
    return r;
  endfunction

  // One clock: drive inputs, advance the model, compare visible outputs.
  // A symbol driven in one step becomes visible after the next step's edge.
  task automatic step(input bit en, input int x, input bit rst);
    exp_t cur, want;
    reset          = ~rst;
    bus.sym_clk_en = en;
    bus.sam_clk_en = en ? 1'b1 : 1'($urandom_range(0, 1));
    bus.in         = en ? 18'(x) : 18'($urandom);
    m_win = 1'b0;
    if (rst) model_reset();
    else if (en) model_sym(x);
    cur = snap(en && !rst);
    @(posedge clk);
    #1;
    want = rst ? cur : prev;
    chk("sym_valid", bus.sym_valid, want.vld);
    chk("win_done",  bus.win_done,  want.win);
    chk("sym_out",   bus.sym_out,   want.sym);
    chk("err_out",   bus.err_out,   want.err);
    chk("ref_level", bus.ref_level, want.ref_l);
    chk("err_pow",   bus.err_pow,   want.pow);
    prev = cur;
  endtask

  vec_t tbl[8];
  int   nvalid, wins;
  int   xr;
  bit   rr, er;

  initial begin
    bus.sym_clk_en = 1'b0;
    bus.sam_clk_en = 1'b0;
    bus.in         = '0;
    model_reset();
    prev = snap(1'b0);

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_ref",   bus.ref_level, 65536);
    chk("rst_fsm",   dut.state_q == ST_ACQ, 1);

    // Single decisions against the initial threshold 65536 (a = 32768)
    tbl[0] = '{x:  98304, sym: 2'b10, err:      0};
    tbl[1] = '{x:      0, sym: 2'b11, err: -32768};
    tbl[2] = '{x: -65536, sym: 2'b00, err:  32768};
    tbl[3] = '{x:  65536, sym: 2'b10, err: -32768};
    tbl[4] = '{x:     -1, sym: 2'b01, err:  32767};
    tbl[5] = '{x:  65535, sym: 2'b11, err:  32767};
    tbl[6] = '{x: 131071, sym: 2'b10, err:  32767};
    tbl[7] = '{x: -65535, sym: 2'b01, err: -32767};
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1);
      step(1, tbl[i].x, 0);
      step(0, 0, 0);
      chk("tbl_sym", bus.sym_out, tbl[i].sym);
      chk("tbl_err", bus.err_out, tbl[i].err);
      step(0, 0, 0);
      chk("tbl_hold", bus.sym_out, tbl[i].sym);
    end

    // Most negative input: outer decision, magnitude saturates to 131071
    step(0, 0, 1);
    step(1, -131072, 0);
    step(1, 0, 0);
    chk("neg_sym", bus.sym_out, 2'b00);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("neg_ref", bus.ref_level, 32767);

    // Back-to-back window of |x|=40000, then decisions against the new ref
    step(0, 0, 1);
    nvalid = 0;
    wins   = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, (i % 2 == 1) ? -40000 : 40000, 0);
      nvalid += int'(bus.sym_valid);
      wins   += int'(bus.win_done);
    end
    step(0, 0, 0);
    nvalid += int'(bus.sym_valid);
    chk("b2b_valid", nvalid, 4);
    chk("win_early", wins, 0);
    chk("win_4th",   bus.win_done, 1);
    chk("win_ref",   bus.ref_level, 40000);
    chk("win_fsm",   dut.state_q == ST_TRACK, 1);
    step(1, 39999, 0);
    step(0, 0, 0);
    chk("t_39999", bus.sym_out, 2'b11);
    step(1, 40000, 0);
    step(0, 0, 0);
    chk("t_40000", bus.sym_out, 2'b10);

    // Reset mid-window discards it
    step(0, 0, 1);
    wins = 0;
    step(1, 5000, 0);
    wins += int'(bus.win_done);
    step(1, 7000, 0);
    wins += int'(bus.win_done);
    step(0, 0, 1);
    wins += int'(bus.win_done);
    for (int i = 0; i < 4; i++) begin
      step(1, 20000, 0);
      wins += int'(bus.win_done);
    end
    step(0, 0, 0);
    wins += int'(bus.win_done);
    chk("mid_wins", wins, 1);
    chk("mid_ref",  bus.ref_level, 20000);

    // All-zero window clamps ref to 1
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("clamp_ref", bus.ref_level, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("clamp_z", bus.sym_out, 2'b11);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("clamp_one", bus.sym_out, 2'b10);

    // Randomized traffic with occasional resets and extreme samples
    for (int i = 0; i < 700; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      er = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       xr = -131072;
        1:       xr = 131071;
        2:       xr = m_ref;
        3:       xr = -m_ref;
        4:       xr = 0;
        default: xr = int'($urandom_range(0, 262143)) - 131072;
      endcase
      step(er, xr, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
